spram_arbiter: RTL and testbench

Round-robin arbiter sharing one single-port async-read/write RAM between `N_REQ` requesters. Each requester presents a read or write command on a valid/grant handshake. The arbiter issues at most one access per clock to the RAM port and returns registered read data tagged to the winning requester. It sits between CPU/DMA/video-style clients and the generic single-port RAM primitive.

---
 rtl/spram_arb_pkg.sv | 33 +++
 rtl/spram_arbiter_rr_pick.sv | 21 ++
 rtl/spram_arbiter.sv | 142 ++++++++++++++
 tb/tb_spram_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// Shared types, limits and a reference round-robin pick for the spram_arbiter slice.
package spram_arb_pkg;

  localparam int SPRAM_ARB_MAX_REQ = 8;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Scan from ptr upward with wrap at n_req; returns the one-hot winner.
  function automatic logic [SPRAM_ARB_MAX_REQ-1:0] rr_pick(
    input logic [SPRAM_ARB_MAX_REQ-1:0] req,
    input logic [2:0]                   ptr,
    input int                           n_req
  );
    logic [SPRAM_ARB_MAX_REQ-1:0] pick;
    logic                         found;
    int                           idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < SPRAM_ARB_MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n_req) idx = idx - n_req;
      if ((k < n_req) && !found && (idx < SPRAM_ARB_MAX_REQ) && req[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/spram_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate by ptr, isolate lowest set bit, rotate back.
module rr_pick_onehot #(
  parameter  int N_REQ = 2,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt
);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] pe;

  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    pe  = rot & (~rot + 1'b1);
    // Upper half of the doubled, left-shifted vector is pe rotated left by ptr.
    gnt = N_REQ'(({pe, pe} << ptr) >> N_REQ);
  end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter for one single-port async-read RAM with registered read return.
// Optional grant locking is enabled by defining SPRAM_ARB_LOCK_EN.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [N_REQ-1:0]            req_lock,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        ram_we,
  output logic                        ram_oe,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_wdata,
  input  logic [DATA_WIDTH-1:0]       ram_rdata
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshake: req[i] is held with its command until gnt[i]=1 in the same
  // cycle; a granted read returns rvalid[i]/rdata exactly one cycle later.

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [N_REQ-1:0]      pick_gnt;
  logic [N_REQ-1:0]      gnt_int;
  logic [PW-1:0]         win_idx;
  logic [N_REQ-1:0]      rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  rr_pick_onehot #(.N_REQ(N_REQ)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt)
  );

`ifdef SPRAM_ARB_LOCK_EN
  localparam logic [0:0] ST_ARB    = ARB;
  localparam logic [0:0] ST_LOCKED = LOCKED;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          lock_active;

  always_comb begin
    lock_active = (state_q == ST_LOCKED) && req_lock[owner_q];
    gnt_int     = '0;
    if (lock_active) gnt_int[owner_q] = req[owner_q];
    else             gnt_int = pick_gnt;
    if (!rst_n) gnt_int = '0;
  end

  // Lock release and normal arbitration happen in the same cycle.
  always_comb begin
    state_d = ST_ARB;
    owner_d = owner_q;
    if (lock_active) begin
      state_d = ST_LOCKED;
    end else if (|(gnt_int & req_lock)) begin
      state_d = ST_LOCKED;
      owner_d = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;

  always_comb begin
    gnt_int = rst_n ? pick_gnt : '0;
  end
`endif

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_int[i]) win_idx = PW'(i);
    end
  end

  // Explicit wrap compare so non power-of-two N_REQ never lands out of range.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt_int) begin
      ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_oe    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_int[i]) begin
        ram_we    = req_we[i];
        ram_oe    = ~req_we[i];
        ram_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rvalid_d = gnt_int & ~req_we;
    rdata_d  = (|rvalid_d) ? ram_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt    = gnt_int;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Table-driven bench for spram_arbiter (N_REQ=3) with a behavioural RAM and read-return scoreboard.
module tb_spram_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int W  = N + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req, req_we, req_lock, gnt, rvalid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rdata, ram_wdata, ram_rdata;
  logic            ram_we, ram_oe;
  logic [AW-1:0]   ram_addr;

  spram_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_lock  (req_lock),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Behavioural single-port RAM: async read, write on the clock edge.
  logic [DW-1:0] ram [8];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] exp_rdata;
  logic [W-1:0]  exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    exp_gnt;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [N-1:0] rq, input logic [N-1:0] wr,
                              input logic [N-1:0] lk,
                              input logic [AW-1:0] a2, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a0,
                              input logic [DW-1:0] d2, input logic [DW-1:0] d1,
                              input logic [DW-1:0] d0, input logic [N-1:0] g);
    vec_t v;
    v.req     = rq;
    v.we      = wr;
    v.lock    = lk;
    v.addr    = {a2, a1, a0};
    v.wdata   = {d2, d1, d0};
    v.exp_gnt = g;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    req       = v.req;
    req_we    = v.we;
    req_lock  = v.lock;
    req_addr  = v.addr;
    req_wdata = v.wdata;
  endtask

  // Drive one command set, check the combinational grant/RAM side, then the read return.
  task automatic step(input vec_t v);
    logic          e_we, e_oe;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [W-1:0]  got;
    logic [W-1:0]  exp;
    drive(v);
    e_we = 1'b0; e_oe = 1'b0; e_addr = '0; e_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (v.exp_gnt[i]) begin
        e_we    = v.we[i];
        e_oe    = ~v.we[i];
        e_addr  = v.addr[i*AW +: AW];
        e_wdata = v.wdata[i*DW +: DW];
      end
    end
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(v.exp_gnt));
    check("ram_we", 32'(ram_we), 32'(e_we));
    check("ram_oe", 32'(ram_oe), 32'(e_oe));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    if ((|v.exp_gnt) && e_oe) begin
      exp_rdata = ref_mem[e_addr];
      exp_q.push_back({v.exp_gnt, exp_rdata});
    end else begin
      exp_q.push_back({{N{1'b0}}, exp_rdata});
    end
    if ((|v.exp_gnt) && e_we) ref_mem[e_addr] = e_wdata;
    @(posedge clk);
    #1;
    got = {rvalid, rdata};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got %0h expected queued entry", got);
    end else begin
      exp = exp_q.pop_front();
      check("rvalid_rdata", 32'(got), 32'(exp));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram[i]     = 8'h10 + 8'(i);
      ref_mem[i] = 8'h10 + 8'(i);
    end
    exp_rdata = '0;

    vecs[0]  = mk(3'b111, 3'b000, 3'b000, 3'd4, 3'd2, 3'd1, 8'h00, 8'h00, 8'h00, 3'b001);
    vecs[1]  = mk(3'b111, 3'b000, 3'b000, 3'd4, 3'd2, 3'd1, 8'h00, 8'h00, 8'h00, 3'b010);
    vecs[2]  = mk(3'b111, 3'b000, 3'b000, 3'd4, 3'd2, 3'd1, 8'h00, 8'h00, 8'h00, 3'b100);
    vecs[3]  = mk(3'b111, 3'b000, 3'b000, 3'd4, 3'd2, 3'd1, 8'h00, 8'h00, 8'h00, 3'b001);
    vecs[4]  = mk(3'b111, 3'b000, 3'b000, 3'd4, 3'd2, 3'd1, 8'h00, 8'h00, 8'h00, 3'b010);
    vecs[5]  = mk(3'b111, 3'b000, 3'b000, 3'd4, 3'd2, 3'd1, 8'h00, 8'h00, 8'h00, 3'b100);
    vecs[6]  = mk(3'b001, 3'b001, 3'b000, 3'd0, 3'd0, 3'd3, 8'h00, 8'h00, 8'hA5, 3'b001);
    vecs[7]  = mk(3'b001, 3'b000, 3'b000, 3'd0, 3'd0, 3'd3, 8'h00, 8'h00, 8'h00, 3'b001);
    vecs[8]  = mk(3'b100, 3'b100, 3'b000, 3'd5, 3'd0, 3'd0, 8'h3C, 8'h00, 8'h00, 3'b100);
    vecs[9]  = mk(3'b000, 3'b000, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'b000);
    vecs[10] = mk(3'b110, 3'b000, 3'b000, 3'd0, 3'd5, 3'd0, 8'h00, 8'h00, 8'h00, 3'b010);
    vecs[11] = mk(3'b011, 3'b010, 3'b000, 3'd0, 3'd7, 3'd5, 8'h00, 8'hC3, 8'h00, 3'b001);
    vecs[12] = mk(3'b011, 3'b010, 3'b000, 3'd0, 3'd7, 3'd5, 8'h00, 8'hC3, 8'h00, 3'b010);
    vecs[13] = mk(3'b100, 3'b000, 3'b000, 3'd7, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'b100);
    vecs[14] = mk(3'b100, 3'b000, 3'b000, 3'd6, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'b100);
    vecs[15] = mk(3'b001, 3'b000, 3'b000, 3'd0, 3'd0, 3'd2, 8'h00, 8'h00, 8'h00, 3'b001);

    // Reset with every requester active: nothing may be granted.
    drive(mk(3'b111, 3'b000, 3'b000, 3'd1, 3'd1, 3'd1, 8'h00, 8'h00, 8'h00, 3'b000));
    @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_ram_we", 32'(ram_we), 32'd0);
    check("reset_ram_oe", 32'(ram_oe), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 16; k++) step(vecs[k]);

`ifdef SPRAM_ARB_LOCK_EN
    step(mk(3'b011, 3'b000, 3'b010, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00, 3'b010));
    step(mk(3'b011, 3'b000, 3'b010, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00, 3'b010));
    step(mk(3'b011, 3'b000, 3'b010, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00, 3'b010));
    step(mk(3'b011, 3'b000, 3'b000, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00, 3'b001));
`else
    step(mk(3'b011, 3'b000, 3'b010, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00, 3'b010));
    step(mk(3'b011, 3'b000, 3'b010, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00, 3'b001));
    step(mk(3'b011, 3'b000, 3'b010, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00, 3'b010));
    step(mk(3'b011, 3'b000, 3'b000, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00, 3'b001));
`endif

    // Reset lands right after a read grant: the pending return is dropped.
    drive(mk(3'b010, 3'b000, 3'b000, 3'd0, 3'd2, 3'd0, 8'h00, 8'h00, 8'h00, 3'b010));
    @(negedge clk);
    check("midread_gnt", 32'(gnt), 32'b010);
    rst_n = 1'b0;
    #1;
    check("midread_gnt_in_reset", 32'(gnt), 32'd0);
    check("midread_ram_oe_in_reset", 32'(ram_oe), 32'd0);
    @(posedge clk);
    #1;
    check("midread_rvalid", 32'(rvalid), 32'd0);
    check("midread_rdata", 32'(rdata), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_rvalid", 32'(rvalid), 32'd0);
    check("post_reset_rdata", 32'(rdata), 32'd0);
    exp_rdata = '0;

    // Pointer is back at 0, and RAM contents survived the reset.
    step(mk(3'b111, 3'b000, 3'b000, 3'd7, 3'd5, 3'd3, 8'h00, 8'h00, 8'h00, 3'b001));
    step(mk(3'b111, 3'b000, 3'b000, 3'd7, 3'd5, 3'd3, 8'h00, 8'h00, 8'h00, 3'b010));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
